cam_stream_gen: RTL
===================

Name: cam_stream_gen

Overview:
- Camera-side transmitter for the capture interface: generates PCLK, Href, VSYNC and an 8-bit pixel bus with OV7670-style timing.
- Pixels are streamed from a frame RAM, or from an internal pattern when built with the optional feature.
- Used as an on-board stand-in for the sensor, feeding the line-buffer/RAM capture logic so the Sobel path can be exercised without a camera attached.
- Runs entirely in the system clock domain. PCLK is a divided output, not a clock inside this block.

Parameters:
- H_ACTIVE, 120, pixels per line (Href high, in PCLK periods)
- H_BLANK, 16, PCLK periods per line with Href low
- V_ACTIVE, 90, active lines per frame
- VSYNC_LINES, 3, line periods with VSYNC high
- V_BACK, 2, line periods between VSYNC fall and the first Href
- V_FRONT, 2, line periods after the last active line
- PCLK_DIV, 4, clk cycles per PCLK period; even, >=4
- ADDR_W, 14, frame RAM address width; 2^ADDR_W >= H_ACTIVE*V_ACTIVE

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  request frames; level-sensitive
- mem_addr  out  ADDR_W  frame RAM read address
- mem_data  in  8  frame RAM read data; valid 1 clk after mem_addr
- PCLK  out  1  pixel clock, 50% duty, period PCLK_DIV clk
- Href  out  1  line valid
- VSYNC  out  1  frame sync, active high
- pixel  out  8  pixel byte
- busy  out  1  high from the first VSYNC rise until the frame ends
- frame_done  out  1  one-clk pulse at the end of V_FRONT

Behaviour:
- Reset values: PCLK=0, Href=0, VSYNC=0, pixel=0, mem_addr=0, busy=0, frame_done=0. FSM=IDLE, all counters 0.
- rst asserted mid-frame: all of the above take their reset values on the next clk; the frame is abandoned and no frame_done pulse is produced.
- PCLK runs continuously after reset, including in IDLE.
  - Low for PCLK_DIV/2 clks, then high for PCLK_DIV/2 clks.
  - First rise occurs PCLK_DIV/2 clks after rst deasserts.
- Output timing: Href, VSYNC and pixel change only on the clk where PCLK falls, so they are stable at every PCLK rising edge (the receiver samples on rising edges).
- Timing counters:
  - Counters advance once per PCLK period.
  - One line period = H_ACTIVE+H_BLANK PCLK periods.
  - hcnt runs 0..line-1; Href=1 for hcnt < H_ACTIVE.
- FSM states:
  - IDLE: enable is sampled at each PCLK fall. enable=1 -> VSYNC (VSYNC and busy go high on that fall).
  - VSYNC: lasts VSYNC_LINES line periods, then -> BACK.
  - BACK: lasts V_BACK line periods, then -> ACTIVE.
  - ACTIVE: lasts V_ACTIVE line periods, with Href asserted per hcnt. Then -> FRONT.
  - FRONT: lasts V_FRONT line periods. At its end: frame_done pulses for 1 clk and busy drops. enable=1 -> VSYNC (back-to-back frame, no gap); enable=0 -> IDLE.
- enable dropped mid-frame: the current frame completes normally, and the FSM then returns to IDLE.
- Memory path:
  - mem_addr is reset to 0 on entry to VSYNC.
  - During ACTIVE, mem_addr is issued on the PCLK-rise clk for the pixel that goes out at the next fall.
  - mem_data is registered one clk later and drives pixel at the next fall.
  - mem_addr increments after each active pixel, reaching H_ACTIVE*V_ACTIVE-1 for the last pixel. It then holds and never wraps within a frame.
  - Pixel k of the frame equals RAM[k], row-major.
- pixel=0 whenever Href=0.
- Exactly H_ACTIVE PCLK rising edges occur with Href=1 per active line, and exactly V_ACTIVE Href pulses occur per frame.

Optional Feature:
- Macro: CAM_STREAM_TEST_PATTERN_EN.
- When defined:
  - pixel = (col XOR row)[7:0], where col is 0..H_ACTIVE-1 and row is 0..V_ACTIVE-1 within the frame.
  - mem_addr is held at 0 and mem_data is ignored.
  - All timing is unchanged.
- When undefined: the RAM path described above is used.

Test Plan:
- Reset, with H_ACTIVE=6, H_BLANK=2, V_ACTIVE=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, PCLK_DIV=4 (used in all tests): release rst with enable=0 -> all outputs 0, PCLK rises at clk 2, 6, 10, …; Href and VSYNC stay 0 for 100 clks.
- Single frame, RAM[k]=k+0x10: pulse enable → VSYNC high for exactly 8 PCLK periods; 8 PCLK periods of Href low follow. Then:
  - 4 Href pulses, each covering exactly 6 rising edges.
  - Sampled pixels are 0x10..0x27 in order.
  - mem_addr max is 23; frame_done pulses once; busy falls on the same clk.
- enable held high → next VSYNC rises on the PCLK fall immediately after the frame_done clk, and mem_addr restarts at 0.
- enable dropped during the 2nd active line → remaining 2 lines are still sent, then IDLE; no further VSYNC.
- rst asserted at hcnt=3 of line 1 → next clk all outputs 0; after release, no frame starts until enable is seen.
- With CAM_STREAM_TEST_PATTERN_EN defined: pixel sampled at row 2, col 3 equals 0x01; row 3, col 5 equals 0x06; mem_addr stays 0.

Source files
------------

// File: rtl/cam_stream_gen.sv
// cam_stream_gen: OV7670-style PCLK/Href/VSYNC/pixel source from frame RAM; CAM_STREAM_TEST_PATTERN_EN selects an internal col^row pattern
module cam_stream_gen #(
  parameter int H_ACTIVE    = 120,
  parameter int H_BLANK     = 16,
  parameter int V_ACTIVE    = 90,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2,
  parameter int PCLK_DIV    = 4,
  parameter int ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              PCLK,
  output logic              Href,
  output logic              VSYNC,
  output logic [7:0]        pixel,
  output logic              busy,
  output logic              frame_done
);
  localparam int LINE = H_ACTIVE + H_BLANK;
  localparam int HW = $clog2(LINE + 1);
  localparam int VW = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);
  localparam int PW = $clog2(PCLK_DIV);
  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_BACK, S_ACTIVE, S_FRONT} state_t;
  state_t state, nxt_state;
  logic [PW-1:0] pcnt;
  logic [HW-1:0] hcnt, nxt_hcnt;
  logic [VW-1:0] vcnt, nxt_vcnt, state_lines;
  logic [7:0] px_src;
  logic rise, fall, pre_fall, line_end, last_line, frame_end, nxt_href, vs_entry;
  assign rise = pcnt == PW'(PCLK_DIV/2 - 1);
  assign fall = pcnt == PW'(PCLK_DIV - 1);
  assign pre_fall = pcnt == PW'(PCLK_DIV - 2);
  always_comb begin
    state_lines = state == S_VSYNC ? VW'(VSYNC_LINES) :
                  state == S_BACK ? VW'(V_BACK) :
                  state == S_ACTIVE ? VW'(V_ACTIVE) : VW'(V_FRONT);
    line_end = hcnt == HW'(LINE - 1);
    last_line = vcnt == state_lines - VW'(1);
    frame_end = state == S_FRONT && line_end && last_line;
    nxt_state = state;
    nxt_hcnt = line_end ? '0 : hcnt + HW'(1);
    nxt_vcnt = vcnt;
    if (state == S_IDLE) begin
      nxt_hcnt = '0;
      nxt_vcnt = '0;
      nxt_state = enable ? S_VSYNC : S_IDLE;
    end else if (line_end) begin
      nxt_vcnt = last_line ? '0 : vcnt + VW'(1);
      if (last_line)
        nxt_state = state == S_VSYNC ? S_BACK :
                    state == S_BACK ? S_ACTIVE :
                    state == S_ACTIVE ? S_FRONT :
                    enable ? S_VSYNC : S_IDLE;
    end
    nxt_href = nxt_state == S_ACTIVE && nxt_hcnt < HW'(H_ACTIVE);
    vs_entry = nxt_state == S_VSYNC && state != S_VSYNC;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      PCLK <= 1'b0;
      state <= S_IDLE;
      hcnt <= '0;
      vcnt <= '0;
      Href <= 1'b0;
      VSYNC <= 1'b0;
      pixel <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pcnt <= fall ? '0 : pcnt + PW'(1);
      PCLK <= rise ? 1'b1 : fall ? 1'b0 : PCLK;
      frame_done <= pre_fall && frame_end;
      if (pre_fall && frame_end) busy <= 1'b0;
      if (fall) begin
        state <= nxt_state;
        hcnt <= nxt_hcnt;
        vcnt <= nxt_vcnt;
        busy <= nxt_state != S_IDLE;
        Href <= nxt_href;
        VSYNC <= nxt_state == S_VSYNC;
        pixel <= nxt_href ? px_src : '0;
      end
    end
  end
`ifdef CAM_STREAM_TEST_PATTERN_EN
  assign mem_addr = '0;
  assign px_src = 8'(nxt_hcnt) ^ 8'(nxt_vcnt);
`else
  logic issued;
  assign px_src = mem_data;
  // address for the upcoming pixel goes out at the rise so RAM data is ready by the fall
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      issued <= 1'b0;
    end else if (fall && vs_entry) begin
      mem_addr <= '0;
      issued <= 1'b0;
    end else if (rise && nxt_href) begin
      if (issued) mem_addr <= mem_addr + ADDR_W'(1);
      issued <= 1'b1;
    end
  end
`endif
endmodule
